// File: rtl/iface_fifo_stage.sv
`default_nettype none
// ============================================================================
//  Module      : iface_fifo_stage
//  Description : Buffered valid/ready byte stage feeding the iface `x` member.
//                Stores up to DEPTH words and presents them in strict FIFO
//                order. It can optionally invert the output word so that it
//                matches the downstream `y = ~x` stage.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                in_valid/in_ready - upstream handshake, in_data word
//                out_valid/out_ready - downstream handshake, out_data word
//                level             - current occupancy, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module iface_fifo_stage #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter bit INVERT = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    localparam logic [LW-1:0]    c_FULL  = LW'(DEPTH);
    localparam logic [WIDTH-1:0] c_IDLE  = INVERT ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    count_q,  count_d;

    logic w_push;
    logic w_pop;
    logic [WIDTH-1:0] w_head;

    // Handshake flags depend on registered occupancy only, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (count_q != c_FULL);
    assign out_valid = (count_q != '0);
    assign level     = count_q;

    assign w_push = in_valid  & in_ready;
    assign w_pop  = out_valid & out_ready;

    assign w_head   = mem_q[rd_ptr_q];
    // Idle value is forced while empty so stale storage never leaks out.
    assign out_data = out_valid ? (INVERT ? ~w_head : w_head) : c_IDLE;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the occupancy counter decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifndef SYNTHESIS
    a_count_range : assert property (@(posedge clk) disable iff (rst)
        count_q <= c_FULL);

    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> $stable(out_data));
`endif

endmodule
`default_nettype wire

// File: tb/tb_iface_fifo_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iface_fifo_stage
//  Description : Directed self-checking bench for iface_fifo_stage. A main
//                instance runs with INVERT=1 and a second instance sharing
//                the same inputs runs with INVERT=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iface_fifo_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] level;

    logic       p_in_ready;
    logic       p_out_valid;
    logic [7:0] p_out_data;
    logic [2:0] p_level;

    int vec_cnt = 0;
    int err_cnt = 0;

    iface_fifo_stage #(.WIDTH(8), .DEPTH(4), .INVERT(1'b1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
    );

    iface_fifo_stage #(.WIDTH(8), .DEPTH(4), .INVERT(1'b0)) u_plain (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (p_in_ready),
        .in_data   (in_data),
        .out_valid (p_out_valid),
        .out_ready (out_ready),
        .out_data  (p_out_data),
        .level     (p_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        vec_cnt++;
        if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vec_cnt++;
        if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vec_cnt++;
        if (level !== 3'd0) begin err_cnt++; $display("FAIL reset_level got %0d want 0", level); end
        vec_cnt++;
        if (out_data !== 8'hFF) begin err_cnt++; $display("FAIL reset_out_data_inv got %h want ff", out_data); end
        vec_cnt++;
        if (p_out_data !== 8'h00) begin err_cnt++; $display("FAIL reset_out_data_plain got %h want 00", p_out_data); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        vec_cnt++;
        if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL single_out_valid got %b want 1", out_valid); end
        vec_cnt++;
        if (level !== 3'd1) begin err_cnt++; $display("FAIL single_level got %0d want 1", level); end
        vec_cnt++;
        if (out_data !== 8'hC3) begin err_cnt++; $display("FAIL single_out_data_inv got %h want c3", out_data); end
        vec_cnt++;
        if (p_out_data !== 8'h3C) begin err_cnt++; $display("FAIL single_out_data_plain got %h want 3c", p_out_data); end
        // Hold with out_ready low: word must persist.
        step();
        vec_cnt++;
        if (out_data !== 8'hC3 || level !== 3'd1) begin
            err_cnt++; $display("FAIL single_hold got data %h level %0d want c3 level 1", out_data, level);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vec_cnt++;
        if (level !== 3'd0 || out_valid !== 1'b0) begin
            err_cnt++; $display("FAIL single_drain got level %0d valid %b want 0 0", level, out_valid);
        end
    endtask

    task automatic fill4();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full();
        fill4();
        vec_cnt++;
        if (level !== 3'd4) begin err_cnt++; $display("FAIL full_level got %0d want 4", level); end
        vec_cnt++;
        if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        in_valid = 1'b1; in_data = 8'h05;
        step();
        in_valid = 1'b0;
        vec_cnt++;
        if (level !== 3'd4) begin err_cnt++; $display("FAIL full_reject_level got %0d want 4", level); end
        for (int i = 1; i <= 4; i++) begin
            vec_cnt++;
            if (out_data !== ~8'(i) || p_out_data !== 8'(i)) begin
                err_cnt++; $display("FAIL full_drain_%0d got %h/%h want %h/%h", i, out_data, p_out_data, ~8'(i), 8'(i));
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        vec_cnt++;
        if (level !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'hFF) begin
            err_cnt++; $display("FAIL full_empty got level %0d valid %b data %h want 0 0 ff", level, out_valid, out_data);
        end
    endtask

    task automatic test_full_pop();
        fill4();
        in_valid = 1'b1; in_data = 8'h05; out_ready = 1'b1;
        // Cycle 1: full, so only the pop of 01 completes.
        vec_cnt++;
        if (in_ready !== 1'b0 || out_data !== 8'hFE) begin
            err_cnt++; $display("FAIL fullpop_c1 got ready %b data %h want 0 fe", in_ready, out_data);
        end
        step();
        vec_cnt++;
        if (level !== 3'd3) begin err_cnt++; $display("FAIL fullpop_lvl1 got %0d want 3", level); end
        // Cycle 2: pop 02 and push 05.
        vec_cnt++;
        if (in_ready !== 1'b1 || out_data !== 8'hFD) begin
            err_cnt++; $display("FAIL fullpop_c2 got ready %b data %h want 1 fd", in_ready, out_data);
        end
        step();
        in_valid = 1'b0;
        vec_cnt++;
        if (level !== 3'd3) begin err_cnt++; $display("FAIL fullpop_lvl2 got %0d want 3", level); end
        for (int i = 3; i <= 5; i++) begin
            vec_cnt++;
            if (p_out_data !== 8'(i)) begin
                err_cnt++; $display("FAIL fullpop_order_%0d got %h want %h", i, p_out_data, 8'(i));
            end
            step();
        end
        out_ready = 1'b0;
        vec_cnt++;
        if (level !== 3'd0) begin err_cnt++; $display("FAIL fullpop_end_level got %0d want 0", level); end
    endtask

    task automatic test_stream();
        logic [7:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i < 10) begin
                in_valid = 1'b1; in_data = 8'h10 + 8'(i);
            end else begin
                in_valid = 1'b0;
            end
            if (i >= 1) begin
                exp = 8'h10 + 8'(i - 1);
                vec_cnt++;
                if (out_valid !== 1'b1 || p_out_data !== exp || out_data !== ~exp || level !== 3'd1) begin
                    err_cnt++;
                    $display("FAIL stream_%0d got valid %b data %h level %0d want 1 %h 1", i, out_valid, p_out_data, level, exp);
                end
            end
            step();
        end
        out_ready = 1'b0;
        vec_cnt++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            err_cnt++; $display("FAIL stream_end got valid %b level %0d want 0 0", out_valid, level);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'h70 + 8'(i);
            step();
        end
        vec_cnt++;
        if (level !== 3'd3) begin err_cnt++; $display("FAIL rstmid_pre_level got %0d want 3", level); end
        // Handshakes offered during reset must not complete.
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        vec_cnt++;
        if (level !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'hFF) begin
            err_cnt++; $display("FAIL rstmid_cleared got level %0d valid %b data %h want 0 0 ff", level, out_valid, out_data);
        end
        in_valid = 1'b1; in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        vec_cnt++;
        if (level !== 3'd1 || out_data !== 8'h5A || p_out_data !== 8'hA5) begin
            err_cnt++; $display("FAIL rstmid_push got level %0d data %h/%h want 1 5a/a5", level, out_data, p_out_data);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vec_cnt++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            err_cnt++; $display("FAIL rstmid_alone got valid %b level %0d want 0 0", out_valid, level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_full_pop();
        test_stream();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
